// File: rtl/cc_miss_req_scheduler.sv
// Cache miss request scheduler: turns accepted miss requests into AXI WRAP8
// read bursts, logs each miss address, and monitors R-channel completions.
module cc_miss_req_scheduler #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic [2:0]  outst_o,
    output logic        err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        wren_q;
    logic [2:0]  outst_q;
    logic [2:0]  beat_q;
    logic        err_q;

    logic accept, ar_hs, r_hs, last_hs, dec, err_ev;

    assign accept  = miss_req_valid_i & miss_req_ready_o;
    assign ar_hs   = mem_arvalid_o & mem_arready_i;
    assign r_hs    = mem_rvalid_i & mem_rready_i;
    assign last_hs = r_hs & mem_rlast_i;
    // A completion with nothing outstanding is an error and must not wrap the count.
    assign dec     = last_hs & (outst_q != 3'd0);
    assign err_ev  = (last_hs && beat_q != 3'd7)
                   || (r_hs && !mem_rlast_i && beat_q == 3'd7)
                   || (r_hs && outst_q == 3'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (ar_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is forced low while reset is held, even though state reads IDLE.
    always_comb begin
        mem_arvalid_o    = (state_q == ISSUE);
        miss_req_ready_o = rst_n && (state_q == IDLE) && (outst_q < MAX_CNT)
                           && !miss_addr_fifo_full_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wren_q <= 1'b0;
        end else begin
            wren_q <= accept;
            if (accept) addr_q <= miss_req_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (ar_hs && !dec)      outst_q <= outst_q + 3'd1;
            else if (!ar_hs && dec) outst_q <= outst_q - 3'd1;

            if (last_hs)   beat_q <= '0;
            else if (r_hs) beat_q <= beat_q + 3'd1;

            if (err_ev) err_q <= 1'b1;
        end
    end

    assign mem_araddr_o           = {addr_q[31:3], 3'b000};
    assign mem_arlen_o            = 4'd7;
    assign mem_arsize_o           = 3'd3;
    assign mem_arburst_o          = 2'b10;
    assign miss_addr_fifo_wren_o  = wren_q;
    assign miss_addr_fifo_wdata_o = addr_q;
    assign outst_o                = outst_q;
    assign err_o                  = err_q;

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// Directed bench for cc_miss_req_scheduler: a per-cycle vector table for a
// clean single miss, then hand-written sequences for stalls, limits and errors.
module tb_cc_miss_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miss_req_valid_i = 1'b0;
    logic [31:0] miss_req_addr_i = '0;
    logic        miss_req_ready_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i = 1'b0;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_rready_i = 1'b1;
    logic        mem_rlast_i = 1'b0;
    logic        miss_addr_fifo_full_i = 1'b0;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic [2:0]  outst_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    cc_miss_req_scheduler #(.MAX_OUTST(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_valid_i       (miss_req_valid_i),
        .miss_req_addr_i        (miss_req_addr_i),
        .miss_req_ready_o       (miss_req_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outst_o                (outst_o),
        .err_o                  (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        arr;
        logic        rv;
        logic        rl;
        logic        full;
        logic        e_rdy;
        logic        e_arv;
        logic        e_wren;
        logic [2:0]  e_outst;
        logic        e_err;
        logic [31:0] e_araddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic v, input logic [31:0] a, input logic arr,
                                input logic rv, input logic rl, input logic full,
                                input logic e_rdy, input logic e_arv, input logic e_wren,
                                input logic [2:0] e_outst, input logic e_err,
                                input logic [31:0] e_araddr, input logic [31:0] e_wdata);
        vec_t r;
        r.v = v; r.a = a; r.arr = arr; r.rv = rv; r.rl = rl; r.full = full;
        r.e_rdy = e_rdy; r.e_arv = e_arv; r.e_wren = e_wren; r.e_outst = e_outst;
        r.e_err = e_err; r.e_araddr = e_araddr; r.e_wdata = e_wdata;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle before sampling.
    task automatic cyc(input logic v, input logic [31:0] a, input logic arr,
                       input logic rv, input logic rl, input logic full);
        @(negedge clk);
        miss_req_valid_i      = v;
        miss_req_addr_i       = a;
        mem_arready_i         = arr;
        mem_rvalid_i          = rv;
        mem_rlast_i           = rl;
        miss_addr_fifo_full_i = full;
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        miss_req_valid_i = 1'b0; miss_req_addr_i = '0; mem_arready_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; miss_addr_fifo_full_i = 1'b0;
        #1;
        check({tag, " rst ready"},   miss_req_ready_o, 0);
        check({tag, " rst arvalid"}, mem_arvalid_o, 0);
        check({tag, " rst araddr"},  mem_araddr_o, 0);
        check({tag, " rst wren"},    miss_addr_fifo_wren_o, 0);
        check({tag, " rst wdata"},   miss_addr_fifo_wdata_o, 0);
        check({tag, " rst outst"},   outst_o, 0);
        check({tag, " rst err"},     err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;

        // Single clean miss, one vector per cycle (beats 0..7 in vecs[2..9]).
        vecs[0]  = mk(1, 32'h0001_2368, 1, 0, 0, 0,  1, 0, 0, 3'd0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 32'h0,         1, 0, 0, 0,  0, 1, 1, 3'd0, 0, 32'h0001_2368, 32'h0001_2368);
        for (int i = 2; i <= 9; i++)
            vecs[i] = mk(0, 32'h0, 1, 1, (i == 9), 0, 1, 0, 0, 3'd1, 0,
                         32'h0001_2368, 32'h0001_2368);
        vecs[10] = mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 3'd0, 0, 32'h0001_2368, 32'h0001_2368);

        // Asynchronous reset: checked before any rising clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("init ready",   miss_req_ready_o, 0);
        check("init arvalid", mem_arvalid_o, 0);
        check("init outst",   outst_o, 0);
        check("init err",     err_o, 0);
        check("init wren",    miss_addr_fifo_wren_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].v, vecs[i].a, vecs[i].arr, vecs[i].rv, vecs[i].rl, vecs[i].full);
            check($sformatf("vec%0d ready", i),  miss_req_ready_o, vecs[i].e_rdy);
            check($sformatf("vec%0d arvalid", i), mem_arvalid_o, vecs[i].e_arv);
            check($sformatf("vec%0d wren", i),   miss_addr_fifo_wren_o, vecs[i].e_wren);
            check($sformatf("vec%0d outst", i),  outst_o, vecs[i].e_outst);
            check($sformatf("vec%0d err", i),    err_o, vecs[i].e_err);
            check($sformatf("vec%0d araddr", i), mem_araddr_o, vecs[i].e_araddr);
            check($sformatf("vec%0d wdata", i),  miss_addr_fifo_wdata_o, vecs[i].e_wdata);
            if (vecs[i].e_arv) begin
                check($sformatf("vec%0d arlen", i),   mem_arlen_o, 4'd7);
                check($sformatf("vec%0d arsize", i),  mem_arsize_o, 3'd3);
                check($sformatf("vec%0d arburst", i), mem_arburst_o, 2'b10);
            end
        end

        // AR stalled 5 cycles; FIFO fills mid-burst and only blocks the next accept.
        do_reset("stall");
        cyc(1, 32'h0000_1004, 0, 0, 0, 0);
        check("stall accept ready", miss_req_ready_o, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h0000_2000, 0, 0, 0, (i >= 2));
            check($sformatf("stall%0d arvalid", i), mem_arvalid_o, 1);
            check($sformatf("stall%0d araddr", i),  mem_araddr_o, 32'h0000_1000);
            check($sformatf("stall%0d ready", i),   miss_req_ready_o, 0);
            cnt += int'(miss_addr_fifo_wren_o);
        end
        cyc(1, 32'h0000_2000, 1, 0, 0, 1);
        check("stall hs arvalid", mem_arvalid_o, 1);
        check("stall hs ready", miss_req_ready_o, 0);
        cnt += int'(miss_addr_fifo_wren_o);
        cyc(1, 32'h0000_2000, 0, 0, 0, 1);
        check("stall post arvalid", mem_arvalid_o, 0);
        check("stall full ready", miss_req_ready_o, 0);
        check("stall outst", outst_o, 1);
        cnt += int'(miss_addr_fifo_wren_o);
        check("stall wren count", cnt, 1);
        cyc(1, 32'h0000_2000, 0, 0, 0, 0);
        check("stall unfull ready", miss_req_ready_o, 1);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("stall2 arvalid", mem_arvalid_o, 1);

        // Reset mid-burst: tracking discarded, nothing reissued.
        do_reset("midburst");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h0, 1, 0, 0, 0);
            check($sformatf("post-rst%0d arvalid", i), mem_arvalid_o, 0);
            check($sformatf("post-rst%0d outst", i),   outst_o, 0);
            check($sformatf("post-rst%0d ready", i),   miss_req_ready_o, 1);
        end

        // Back-to-back misses hit the outstanding limit of 4.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'h0000_4000 + 32'(i * 64), 1, 0, 0, 0);
            cnt += int'(mem_arvalid_o);
        end
        check("limit ar count", cnt, 4);
        check("limit outst", outst_o, 4);
        check("limit ready", miss_req_ready_o, 0);
        for (int b = 0; b < 8; b++) begin
            cyc(1, 32'h0000_5008, 1, 1, (b == 7), 0);
            check($sformatf("limit beat%0d ready", b), miss_req_ready_o, 0);
        end
        cyc(1, 32'h0000_5008, 1, 0, 0, 0);
        check("limit release ready", miss_req_ready_o, 1);
        check("limit release outst", outst_o, 3);
        cyc(0, 32'h0, 1, 0, 0, 0);
        check("fifth arvalid", mem_arvalid_o, 1);
        check("fifth araddr", mem_araddr_o, 32'h0000_5008);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("fifth outst", outst_o, 4);
        check("fifth err", err_o, 0);

        // AR handshake coinciding with a completion leaves the count unchanged.
        do_reset("coincide");
        for (int i = 0; i < 4; i++) cyc(1, 32'h0000_6000, 1, 0, 0, 0);
        for (int b = 0; b < 7; b++) cyc(0, 32'h0, 0, 1, 0, 0);
        check("coincide pre outst", outst_o, 2);
        cyc(1, 32'h0000_7000, 0, 0, 0, 0);
        check("coincide accept ready", miss_req_ready_o, 1);
        cyc(0, 32'h0, 1, 1, 1, 0);
        check("coincide arvalid", mem_arvalid_o, 1);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("coincide outst", outst_o, 2);
        check("coincide err", err_o, 0);

        // Early rlast sets a sticky error that survives a later legal burst.
        do_reset("early");
        cyc(1, 32'h0000_8000, 1, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0, 0);
        for (int b = 0; b < 6; b++) cyc(0, 32'h0, 0, 1, (b == 5), 0);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("early err", err_o, 1);
        check("early outst", outst_o, 0);
        cyc(1, 32'h0000_9000, 1, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0, 0);
        for (int b = 0; b < 8; b++) cyc(0, 32'h0, 0, 1, (b == 7), 0);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("sticky err", err_o, 1);
        check("sticky outst", outst_o, 0);

        // R beat with nothing outstanding: error, count stays at zero.
        do_reset("orphan");
        cyc(0, 32'h0, 0, 1, 1, 0);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("orphan err", err_o, 1);
        check("orphan outst", outst_o, 0);

        // FIFO full blocks acceptance; release lets the request in next edge.
        do_reset("full");
        cyc(1, 32'h0000_A00C, 0, 0, 0, 1);
        check("full ready0", miss_req_ready_o, 0);
        cyc(1, 32'h0000_A00C, 0, 0, 0, 1);
        check("full ready1", miss_req_ready_o, 0);
        check("full wren", miss_addr_fifo_wren_o, 0);
        check("full arvalid", mem_arvalid_o, 0);
        cyc(1, 32'h0000_A00C, 0, 0, 0, 0);
        check("unfull ready", miss_req_ready_o, 1);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("unfull wren", miss_addr_fifo_wren_o, 1);
        check("unfull wdata", miss_addr_fifo_wdata_o, 32'h0000_A00C);
        check("unfull araddr", mem_araddr_o, 32'h0000_A008);
        cyc(0, 32'h0, 0, 0, 0, 0);
        check("unfull wren pulse", miss_addr_fifo_wren_o, 0);
        check("unfull arvalid hold", mem_arvalid_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
